// File: rtl/mod_counter.sv
// Run-time programmable modulo counter: up/down, variable step, variable limit.
// Define MOD_COUNTER_SAT_EN to clamp at the bounds instead of wrapping.
module mod_counter #(
  parameter int WORD_SIZE = 32,
  parameter int STEP_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 count_enable,
  input  logic                 dir,
  input  logic [STEP_SIZE-1:0] step,
  input  logic [WORD_SIZE-1:0] limit,
  input  logic [WORD_SIZE-1:0] load_data,
  output logic [WORD_SIZE-1:0] count,
  output logic                 terminal,
  output logic                 zero
);

  localparam int XW = WORD_SIZE + 1;

  logic [WORD_SIZE-1:0] count_q, count_d;
  logic                 term_q, term_d;

  logic [XW-1:0] cnt_x, lim_x, mod_x, step_x;
  logic [XW-1:0] up_sum, up_wrap, dn_diff, dn_wrap;
  logic          step_nz, out_rng, up_ovf, dn_unf;

  assign cnt_x   = {1'b0, count_q};
  assign lim_x   = {1'b0, limit};
  assign mod_x   = lim_x + XW'(1);
  assign step_x  = {{(XW-STEP_SIZE){1'b0}}, step};
  assign step_nz = (step != '0);
  assign out_rng = (count_q > limit);

  assign up_sum  = cnt_x + step_x;
  assign up_ovf  = (up_sum > lim_x);
  assign up_wrap = up_sum - mod_x;
  assign dn_unf  = (step_x > cnt_x);
  assign dn_diff = cnt_x - step_x;
  assign dn_wrap = cnt_x + mod_x - step_x;

  always_comb begin
    count_d = count_q;
    term_d  = 1'b0;
    if (load) begin
      count_d = load_data;
    end else if (count_enable && step_nz) begin
      if (out_rng) begin
        term_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
        count_d = limit;
`else
        count_d = dir ? limit : '0;
`endif
      end else if (!dir) begin
        if (up_ovf) begin
          term_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          count_d = limit;
`else
          // Oversized steps cannot leave the range.
          count_d = (up_wrap > lim_x) ? '0 : up_wrap[WORD_SIZE-1:0];
`endif
        end else begin
          count_d = up_sum[WORD_SIZE-1:0];
        end
      end else begin
        if (dn_unf) begin
          term_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
          count_d = '0;
`else
          count_d = (dn_wrap > lim_x) ? '0 : dn_wrap[WORD_SIZE-1:0];
`endif
        end else begin
          count_d = dn_diff[WORD_SIZE-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      term_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      term_q  <= term_d;
    end
  end

  assign count    = count_q;
  assign terminal = term_q;
  assign zero     = (count_q == '0);

endmodule

// File: doc/mod_counter.md
# mod_counter

Synchronous, parametrised modulo counter that generalises the plain posedge up/down counter with a run-time direction, a programmable step and a programmable wrap limit. Each enabled cycle it adds or subtracts `step` modulo `limit+1`, and it flags every wrap with a registered terminal pulse. It serves as the loop and index counter for the ODE accelerator's iteration and address sequencing, where loop bounds and strides are set at run time.

## Interface
- `WORD_SIZE`, default 32: width of `count`, `load_data` and `limit`.
- `STEP_SIZE`, default 8: width of `step`; must satisfy `STEP_SIZE <= WORD_SIZE`.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `load`  in  1  load `load_data` into `count`.
- `count_enable`  in  1  advance `count` by one step.
- `dir`  in  1  0 = count up, 1 = count down.
- `step`  in  STEP_SIZE  unsigned increment per enabled cycle; zero-extended to `WORD_SIZE`.
- `limit`  in  WORD_SIZE  largest legal count value; the modulus is `limit+1`.
- `load_data`  in  WORD_SIZE  value captured on `load`.
- `count`  out  WORD_SIZE  registered count.
- `terminal`  out  1  registered; high for one cycle after a wrap or clamp.
- `zero`  out  1  `count == 0`, decoded from the register (no input path).

## Operation
- Priority per edge: `rst` > `load` > `count_enable` > hold.
- `rst`: `count` = 0, `terminal` = 0, so `zero` = 1.
- `load`: `count` = `load_data`, `terminal` = 0, and `dir`, `step` and `limit` are ignored. `load_data > limit` is accepted as is.
- Enable with `step == 0`: `count` holds and `terminal` = 0.
- Enable with `count > limit` (out of range after a load, or after `limit` shrinks): next `count` = 0 when counting up or `limit` when counting down. `terminal` = 1.
- Enable, counting up, in range. Evaluate `s = count + step` in `WORD_SIZE+1` bits.
  - If `s > limit`: `count` = `s - (limit+1)` and `terminal` = 1.
  - Otherwise `count` = `s` and `terminal` = 0.
- Enable, counting down, in range:
  - If `step > count`: `count` = `count + (limit+1) - step` and `terminal` = 1.
  - Otherwise `count` = `count - step` and `terminal` = 0.
- All modulus arithmetic is `WORD_SIZE+1` bits wide. This covers two edge cases:
  - `limit` = all-ones gives natural 2^WORD_SIZE wrap.
  - `limit` = 0 holds `count` at 0 and pulses `terminal` on every enabled cycle with a nonzero step.
- A step larger than `limit+1` is a caller error. The result is defined only as `count` ∈ [0, `limit`], with `terminal` = 1.
- No enable: `terminal` = 0.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `count` and `terminal` after edge N.
- `terminal` is coincident with the wrapped `count` value, never with the pre-wrap value.
- Consecutive enabled wrapping cycles give `terminal` high for consecutive cycles; it is not edge-detected.
- Reset asserted mid-count takes effect at the next edge regardless of `load` or `count_enable`.
- `dir`, `step` and `limit` may change every cycle; each edge uses only the values sampled at that edge.
- The critical path is add/subtract, then compare, then subtract over `WORD_SIZE+1` bits.

## Configuration
- `MOD_COUNTER_SAT_EN` defined: the counter saturates instead of wrapping.
  - Counting up where `count + step > limit`: `count` = `limit`.
  - Counting down where `step > count`: `count` = 0.
  - `terminal` = 1 on every enabled cycle that clamps, including when already at the bound with a nonzero step.
  - Out-of-range `count` clamps to `limit` in both directions.
- Macro undefined: modulo wrap as described in Operation. Ports are identical in both builds.

## Test plan
- WORD_SIZE=8, `limit`=9, `step`=1, `dir`=0, reset, then 10 enables -> `count` steps 1..9 then 0. `terminal` is high only on the cycle `count` returns to 0, and `zero` is high at that point.
- `load_data`=1 loaded, then `dir`=1, `step`=3, `limit`=9, one enable -> `count`=8 with `terminal`=1. A second enable gives `count`=5 with `terminal`=0.
- `limit`=255, `count`=255, `step`=1, up -> `count`=0 and `terminal`=1. Then `dir`=1 with one enable -> `count`=255 and `terminal`=1.
- `load`=1 with `count_enable`=1 and `load_data`=42 -> `count`=42 and `terminal`=0. Then `rst` together with `load` -> `count`=0.
- Load 20 with `limit`=9, then one enable up -> `count`=0 and `terminal`=1. One enable with `step`=0 -> `count` holds, `terminal`=0.
- With `MOD_COUNTER_SAT_EN`: `limit`=9, `count`=8, `step`=4, up -> `count`=9 and `terminal`=1. Another enable -> `count`=9 and `terminal`=1.
